// File: rtl/dc_fifo_responder_if.sv
// TCDM request/response bus shared by the FIFO responder and its masters.
// The master drives the request fields; the slave answers with grant and response data.
interface XBAR_TCDM_BUS;
  logic        req;
  logic [31:0] add;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic [31:0] r_rdata;
  logic        r_valid;

  modport Master (output req, add, wen, wdata, be, input gnt, r_rdata, r_valid);
  modport Slave  (input req, add, wen, wdata, be, output gnt, r_rdata, r_valid);
endinterface

// File: rtl/dc_fifo_responder.sv
// TCDM responder bridging a TX stream FIFO (filled by DATA writes) and an RX stream FIFO
// (drained by DATA reads). Blocked DATA accesses stall and are force-completed after TIMEOUT cycles.
module dc_fifo_responder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  XBAR_TCDM_BUS.Slave      l2_slave,
  output logic             tx_valid_o,
  output logic [31:0]      tx_data_o,
  input  logic             tx_ready_i,
  input  logic             rx_valid_i,
  input  logic [31:0]      rx_data_i,
  output logic             rx_ready_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {IDLE, STALL} state_e;

  state_e        state_q, state_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;

  logic [31:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_wr_q, tx_rd_q, rx_wr_q, rx_rd_q;
  logic [LW-1:0] tx_level_q, rx_level_q;

  logic          err_q;
  logic          r_valid_q;
  logic [31:0]   r_rdata_q, rdata_d;
  logic [31:0]   wdata_masked;

  logic is_data, is_status, tx_full, tx_empty, rx_full, rx_empty;
  logic data_ok, blocked, timeout_hit, gnt;
  logic tx_push, tx_pop, rx_push, rx_pop, status_clear;
  logic unused_add;

  assign is_data   = (l2_slave.add[3:2] == 2'd0);
  assign is_status = (l2_slave.add[3:2] == 2'd1);
  assign unused_add = ^{l2_slave.add[31:4], l2_slave.add[1:0]};

  assign tx_full  = (tx_level_q == LW'(DEPTH));
  assign tx_empty = (tx_level_q == '0);
  assign rx_full  = (rx_level_q == LW'(DEPTH));
  assign rx_empty = (rx_level_q == '0);

  assign data_ok     = l2_slave.wen ? !rx_empty : !tx_full;
  assign blocked     = l2_slave.req && is_data && !data_ok;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == STALL) &&
                       (stall_cnt_q == 32'(TIMEOUT)) && blocked;
  // Grant is combinational with req but forced low while reset is asserted.
  assign gnt = rst_ni && l2_slave.req && (!is_data || data_ok || timeout_hit);

  assign tx_push      = gnt && is_data && !l2_slave.wen && !tx_full;
  assign tx_pop       = tx_valid_o && tx_ready_i;
  assign rx_push      = rx_valid_i && rx_ready_o;
  assign rx_pop       = gnt && is_data && l2_slave.wen && !rx_empty;
  assign status_clear = gnt && is_status && !l2_slave.wen &&
                        l2_slave.wdata[31] && l2_slave.be[3];

  assign tx_valid_o       = !tx_empty;
  assign tx_data_o        = tx_mem[tx_rd_q];
  assign rx_ready_o       = !rx_full;
  assign l2_slave.gnt     = gnt;
  assign l2_slave.r_valid = r_valid_q;
  assign l2_slave.r_rdata = r_rdata_q;

  always_comb begin
    wdata_masked = '0;
    for (int b = 0; b < 4; b++) begin
      if (l2_slave.be[b]) wdata_masked[8*b +: 8] = l2_slave.wdata[8*b +: 8];
    end
  end

  always_comb begin
    rdata_d = '0;
    if (timeout_hit)                    rdata_d = 32'hDEADBEEF;
    else if (is_data && l2_slave.wen)   rdata_d = rx_mem[rx_rd_q];
    else if (is_status && l2_slave.wen) rdata_d = {err_q, 13'd0, rx_empty, tx_full,
                                                   8'(rx_level_q), 8'(tx_level_q)};
  end

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (blocked) begin
          state_d     = STALL;
          stall_cnt_d = 32'd1;
        end
      end
      STALL: begin
        if (!l2_slave.req || gnt) begin
          state_d     = IDLE;
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + 32'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        stall_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
      r_valid_q   <= 1'b0;
      r_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      r_valid_q   <= gnt;
      if (gnt) r_rdata_q <= rdata_d;
      if (timeout_hit)       err_q <= 1'b1;
      else if (status_clear) err_q <= 1'b0;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_level_q <= '0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_level_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
      if (tx_push && !tx_pop)      tx_level_q <= tx_level_q + LW'(1);
      else if (!tx_push && tx_pop) tx_level_q <= tx_level_q - LW'(1);
      if (rx_push) rx_wr_q <= rx_wr_q + AW'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + AW'(1);
      if (rx_push && !rx_pop)      rx_level_q <= rx_level_q + LW'(1);
      else if (!rx_push && rx_pop) rx_level_q <= rx_level_q - LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (tx_push) tx_mem[tx_wr_q] <= wdata_masked;
    if (rx_push) rx_mem[rx_wr_q] <= rx_data_i;
  end

endmodule

// File: tb/tb_dc_fifo_responder.sv
// Directed bench for dc_fifo_responder with DEPTH=4 and TIMEOUT=8; expected values are hand-computed.
module tb_dc_fifo_responder;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [31:0] tx_data, rx_data;
  int          checks = 0;
  int          errors = 0;

  XBAR_TCDM_BUS l2_bus ();

  dc_fifo_responder #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .l2_slave   (l2_bus),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .tx_ready_i (tx_ready),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .rx_ready_o (rx_ready)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_stimulus(input logic req, input logic wen, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
    l2_bus.req   = req;
    l2_bus.wen   = wen;
    l2_bus.add   = addr;
    l2_bus.wdata = wdata;
    l2_bus.be    = be;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    // Reset state, with a DATA write request held to show gnt stays low.
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'h1, 4'hF);
    tick;
    check_output("rst_gnt", 32'(l2_bus.gnt), 32'd0);
    check_output("rst_rvalid", 32'(l2_bus.r_valid), 32'd0);
    check_output("rst_rdata", l2_bus.r_rdata, 32'h0);
    check_output("rst_txvalid", 32'(tx_valid), 32'd0);
    check_output("rst_rxready", 32'(rx_ready), 32'd1);
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    tick;
    rst_ni = 1'b1;
    tick;

    // Full and partial byte-enable writes to DATA.
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'h11223344, 4'hF);
    check_output("wr1_gnt", 32'(l2_bus.gnt), 32'd1);
    tick;
    check_output("wr1_rvalid", 32'(l2_bus.r_valid), 32'd1);
    check_output("wr1_rdata", l2_bus.r_rdata, 32'h0);
    check_output("wr1_txvalid", 32'(tx_valid), 32'd1);
    check_output("wr1_txdata", tx_data, 32'h11223344);
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'hAABBCCDD, 4'h3);
    check_output("wr2_gnt", 32'(l2_bus.gnt), 32'd1);
    tick;
    check_output("wr2_rvalid", 32'(l2_bus.r_valid), 32'd1);
    tx_ready = 1'b1;
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    tick;
    check_output("idle_rvalid", 32'(l2_bus.r_valid), 32'd0);
    check_output("wr2_txdata", tx_data, 32'h0000CCDD);
    tick;
    tx_ready = 1'b0;
    check_output("tx_drained", 32'(tx_valid), 32'd0);

    // Fill TX to DEPTH, then a fifth write stalls until one pop.
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0, 32'hA0000001 + 32'(i), 4'hF);
      check_output("fill_gnt", 32'(l2_bus.gnt), 32'd1);
      tick;
    end
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'hA0000005, 4'hF);
    check_output("w5_blocked", 32'(l2_bus.gnt), 32'd0);
    tick;
    tx_ready = 1'b1;
    #1;
    check_output("w5_still_blocked", 32'(l2_bus.gnt), 32'd0);
    tick;
    tx_ready = 1'b0;
    #1;
    check_output("w5_granted", 32'(l2_bus.gnt), 32'd1);
    tick;
    check_output("w5_rvalid", 32'(l2_bus.r_valid), 32'd1);
    check_output("w5_head", tx_data, 32'hA0000002);
    apply_stimulus(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
    tick;
    check_output("status_txfull", l2_bus.r_rdata, 32'h00030004);
    tx_ready = 1'b1;
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    tick;
    check_output("drain_head", tx_data, 32'hA0000003);
    tick;
    tick;
    tick;
    tx_ready = 1'b0;
    check_output("tx_empty_again", 32'(tx_valid), 32'd0);

    // DATA read on empty RX completes the cycle after a late push.
    apply_stimulus(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
    check_output("rd_blocked", 32'(l2_bus.gnt), 32'd0);
    tick;
    tick;
    tick;
    rx_valid = 1'b1;
    rx_data  = 32'hCAFEF00D;
    #1;
    check_output("rd_push_cycle_gnt", 32'(l2_bus.gnt), 32'd0);
    tick;
    rx_valid = 1'b0;
    #1;
    check_output("rd_after_push_gnt", 32'(l2_bus.gnt), 32'd1);
    tick;
    check_output("rd_rvalid", 32'(l2_bus.r_valid), 32'd1);
    check_output("rd_rdata", l2_bus.r_rdata, 32'hCAFEF00D);

    // Timeout on a held read, then sticky error handling.
    apply_stimulus(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
    check_output("to_first", 32'(l2_bus.gnt), 32'd0);
    for (int i = 1; i < 8; i++) begin
      tick;
      check_output("to_wait", 32'(l2_bus.gnt), 32'd0);
    end
    tick;
    check_output("to_gnt", 32'(l2_bus.gnt), 32'd1);
    tick;
    check_output("to_rvalid", 32'(l2_bus.r_valid), 32'd1);
    check_output("to_rdata", l2_bus.r_rdata, 32'hDEADBEEF);
    apply_stimulus(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
    check_output("st_gnt", 32'(l2_bus.gnt), 32'd1);
    tick;
    check_output("st_err_set", l2_bus.r_rdata, 32'h80020000);
    apply_stimulus(1'b1, 1'b1, 32'h8, 32'h0, 4'h0);
    tick;
    check_output("rsv_rvalid", 32'(l2_bus.r_valid), 32'd1);
    check_output("rsv_rdata", l2_bus.r_rdata, 32'h0);
    apply_stimulus(1'b1, 1'b0, 32'h4, 32'h80000000, 4'h7);
    tick;
    apply_stimulus(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
    tick;
    check_output("st_err_kept", l2_bus.r_rdata, 32'h80020000);
    apply_stimulus(1'b1, 1'b0, 32'h4, 32'h80000000, 4'hF);
    tick;
    check_output("st_wr_rdata", l2_bus.r_rdata, 32'h0);
    apply_stimulus(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
    tick;
    check_output("st_err_clr", l2_bus.r_rdata, 32'h00020000);

    // Simultaneous RX push and pop at level 2; back-to-back STATUS reads.
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    rx_valid = 1'b1;
    rx_data  = 32'h1;
    tick;
    rx_data  = 32'h2;
    tick;
    rx_data  = 32'h3;
    apply_stimulus(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
    check_output("pp_gnt", 32'(l2_bus.gnt), 32'd1);
    tick;
    rx_valid = 1'b0;
    check_output("pp_rdata", l2_bus.r_rdata, 32'h1);
    apply_stimulus(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
    tick;
    check_output("b2b_st1_rvalid", 32'(l2_bus.r_valid), 32'd1);
    check_output("b2b_st1_rdata", l2_bus.r_rdata, 32'h00000200);
    tick;
    check_output("b2b_st2_rvalid", 32'(l2_bus.r_valid), 32'd1);
    check_output("b2b_st2_rdata", l2_bus.r_rdata, 32'h00000200);

    // RX full: a push is refused even when a pop happens the same cycle.
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    rx_valid = 1'b1;
    rx_data  = 32'h4;
    tick;
    rx_data  = 32'h5;
    tick;
    rx_data  = 32'h6;
    #1;
    check_output("rx_full_ready", 32'(rx_ready), 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h0, 32'h0, 4'h0);
    check_output("full_pop_gnt", 32'(l2_bus.gnt), 32'd1);
    tick;
    rx_valid = 1'b0;
    check_output("full_pop_rdata", l2_bus.r_rdata, 32'h2);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 1'b0, 32'h0, 32'hB0000000 + 32'(i), 4'hF);
      tick;
    end
    apply_stimulus(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
    tick;
    check_output("st_levels", l2_bus.r_rdata, 32'h00010304);

    // Reset in the middle of a stall with both FIFOs occupied.
    apply_stimulus(1'b1, 1'b0, 32'h0, 32'hB0000005, 4'hF);
    check_output("pre_rst_blocked", 32'(l2_bus.gnt), 32'd0);
    tick;
    tick;
    rst_ni = 1'b0;
    #1;
    check_output("mid_rst_gnt", 32'(l2_bus.gnt), 32'd0);
    check_output("mid_rst_rvalid", 32'(l2_bus.r_valid), 32'd0);
    check_output("mid_rst_rdata", l2_bus.r_rdata, 32'h0);
    check_output("mid_rst_txvalid", 32'(tx_valid), 32'd0);
    check_output("mid_rst_rxready", 32'(rx_ready), 32'd1);
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    tick;
    rst_ni = 1'b1;
    tick;
    check_output("post_rst_rvalid", 32'(l2_bus.r_valid), 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h4, 32'h0, 4'h0);
    check_output("post_rst_gnt", 32'(l2_bus.gnt), 32'd1);
    tick;
    check_output("post_rst_status", l2_bus.r_rdata, 32'h00020000);
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
